// File: rtl/out_port_fifo.sv
// Output-port stage: captures OUT-destination writes from the source bus into a
// small show-ahead FIFO, drains it to an external device over valid/ready, and
// keeps the last accepted value on outbuf for read-back through the source mux.
module out_port_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] srcout,
    input  logic              wr_en,
    output logic [DATA_W-1:0] outbuf,
    output logic [DATA_W-1:0] dev_data,
    output logic              dev_valid,
    input  logic              dev_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] outbuf_q, outbuf_d;
    logic              ovf_q, ovf_d;

    logic pop;
    logic push;
    logic drop;

    // Status flags come straight from the registered count so they never glitch.
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign dev_valid = !empty;
    assign count     = count_q;
    assign outbuf    = outbuf_q;
    assign overflow  = ovf_q;
    assign dev_data  = mem_q[rptr_q];

    // A pop on the same edge frees a slot, so a full FIFO can still accept a write.
    assign pop  = dev_valid & dev_ready;
    assign push = wr_en & (!full | pop);
    assign drop = wr_en & full & !pop;

    // Next-state for pointers, occupancy, read-back register and sticky overflow.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        outbuf_d = outbuf_q;
        ovf_d    = ovf_q;
        if (push) begin
            wptr_d   = wptr_q + 1'b1;
            outbuf_d = srcout;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Setting beats clearing when a drop and clr_ovf coincide.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers, cleared asynchronously so reset cuts any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            outbuf_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            outbuf_q <= outbuf_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage entries are cleared on reset so dev_data reads zero afterwards.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Each entry loads srcout when it is the write target of a push.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (push && (wptr_q == ADDR_W'(gi))) begin
                    mem_q[gi] <= srcout;
                end
            end
        end
    endgenerate

endmodule
